// File: rtl/hazard_int_ctrl.sv
// hazard_int_ctrl
//   Pipeline control unit. It raises stall/IF_flush for the IF/ID and ID/EX
//   registers on load-use and MDU hazards. It accepts external interrupts
//   precisely, squashing the ID instruction and saving its PC to EPC, and it
//   handles ERET. It also drives PC select and the EXL set/clear controls.
//
// Ports
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   MemRead_ex_i, rt_ex_i     load in EX and its destination register
//   rs_id_i, rt_id_i          ID source fields
//   use_rs_id_i, use_rt_id_i  ID instruction reads rs / rt
//   valid_id_i, PC_id_i       ID holds a real instruction; its PC
//   eret_id_i                 ID instruction is ERET
//   mdu_start_ex_i            EX issues mult/div this cycle
//   mdu_use_id_i              ID reads HI/LO or issues mult/div
//   int_req_i, IE_i, EXL_i    interrupt request level, Status.IE, Status.EXL
//   stall_o, IF_flush_o       pipeline hold / flush
//   PC_sel_o                  00 normal, 01 handler vector, 10 EPC
//   EPC_we_o, EPC_o           EPC write strobe and value
//   EXL_set_o, EXL_clr_o      Status.EXL set / clear
//   int_ack_o                 one-cycle interrupt accept pulse
//   mdu_busy_o                MDU result not yet valid
module hazard_int_ctrl #(
  parameter int unsigned MDU_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_ex_i,
  input  logic [4:0]  rt_ex_i,
  input  logic [4:0]  rs_id_i,
  input  logic [4:0]  rt_id_i,
  input  logic        use_rs_id_i,
  input  logic        use_rt_id_i,
  input  logic        valid_id_i,
  input  logic [31:0] PC_id_i,
  input  logic        eret_id_i,
  input  logic        mdu_start_ex_i,
  input  logic        mdu_use_id_i,
  input  logic        int_req_i,
  input  logic        IE_i,
  input  logic        EXL_i,
  output logic        stall_o,
  output logic        IF_flush_o,
  output logic [1:0]  PC_sel_o,
  output logic        EPC_we_o,
  output logic [31:0] EPC_o,
  output logic        EXL_set_o,
  output logic        EXL_clr_o,
  output logic        int_ack_o,
  output logic        mdu_busy_o
);

  localparam int unsigned CW = $clog2(MDU_CYCLES + 1);

  typedef enum logic [1:0] {RUN, INT_WAIT, ERET_WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;

  logic lu_hz, busy, mdu_hz, hz, int_pend, accept, eret_go;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      // A new issue while busy reloads; the unit restarts its latency.
      if (mdu_start_ex_i)
        cnt <= CW'(MDU_CYCLES);
      else if (cnt != '0)
        cnt <= cnt - CW'(1);
    end
  end

  always_comb begin
    lu_hz    = MemRead_ex_i && (rt_ex_i != 5'd0) &&
               ((use_rs_id_i && (rs_id_i == rt_ex_i)) ||
                (use_rt_id_i && (rt_id_i == rt_ex_i)));
    busy     = (cnt != '0);
    mdu_hz   = mdu_use_id_i && (busy || mdu_start_ex_i);
    hz       = lu_hz || mdu_hz;
    int_pend = int_req_i && IE_i && !EXL_i;
    // Accept waits until the MDU is idle so EPC replay cannot lose HI/LO.
    accept   = (state == RUN) && int_pend && valid_id_i && !hz &&
               !busy && !mdu_start_ex_i;
    eret_go  = (state == RUN) && eret_id_i && valid_id_i && !hz && !accept;

    state_nxt  = state;
    stall_o    = 1'b0;
    IF_flush_o = 1'b0;
    PC_sel_o   = 2'b00;
    EPC_we_o   = 1'b0;
    EPC_o      = '0;
    EXL_set_o  = 1'b0;
    EXL_clr_o  = 1'b0;
    int_ack_o  = 1'b0;
    mdu_busy_o = 1'b0;

    // Outputs are forced low for the whole reset assertion, not only at edges.
    if (!rst) begin
      stall_o    = hz;
      mdu_busy_o = busy;
      unique case (state)
        RUN: begin
          if (accept) begin
            IF_flush_o = 1'b1;
            PC_sel_o   = 2'b01;
            EPC_we_o   = 1'b1;
            EPC_o      = PC_id_i;
            EXL_set_o  = 1'b1;
            int_ack_o  = 1'b1;
            state_nxt  = INT_WAIT;
          end else if (eret_go) begin
            IF_flush_o = 1'b1;
            PC_sel_o   = 2'b10;
            EXL_clr_o  = 1'b1;
            state_nxt  = ERET_WAIT;
          end
        end
        INT_WAIT:  if (EXL_i)  state_nxt = RUN;
        ERET_WAIT: if (!EXL_i) state_nxt = RUN;
        default:   state_nxt = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_int_ctrl.sv
// tb_hazard_int_ctrl
//   Directed bench for hazard_int_ctrl. Each step drives inputs on the falling
//   edge, queues the expected output word, and compares it shortly before the
//   next rising edge.
module tb_hazard_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_ex_i, use_rs_id_i, use_rt_id_i, valid_id_i, eret_id_i;
  logic        mdu_start_ex_i, mdu_use_id_i, int_req_i, IE_i, EXL_i;
  logic [4:0]  rt_ex_i, rs_id_i, rt_id_i;
  logic [31:0] PC_id_i;
  logic        stall_o, IF_flush_o, EPC_we_o, EXL_set_o, EXL_clr_o;
  logic        int_ack_o, mdu_busy_o;
  logic [1:0]  PC_sel_o;
  logic [31:0] EPC_o;

  hazard_int_ctrl #(.MDU_CYCLES(5)) dut (
    .clk(clk), .rst(rst),
    .MemRead_ex_i(MemRead_ex_i), .rt_ex_i(rt_ex_i),
    .rs_id_i(rs_id_i), .rt_id_i(rt_id_i),
    .use_rs_id_i(use_rs_id_i), .use_rt_id_i(use_rt_id_i),
    .valid_id_i(valid_id_i), .PC_id_i(PC_id_i), .eret_id_i(eret_id_i),
    .mdu_start_ex_i(mdu_start_ex_i), .mdu_use_id_i(mdu_use_id_i),
    .int_req_i(int_req_i), .IE_i(IE_i), .EXL_i(EXL_i),
    .stall_o(stall_o), .IF_flush_o(IF_flush_o), .PC_sel_o(PC_sel_o),
    .EPC_we_o(EPC_we_o), .EPC_o(EPC_o), .EXL_set_o(EXL_set_o),
    .EXL_clr_o(EXL_clr_o), .int_ack_o(int_ack_o), .mdu_busy_o(mdu_busy_o)
  );

  always #5 clk = ~clk;

  // Control word: {stall, flush, pc_sel[1:0], epc_we, exl_set, exl_clr, ack, busy}
  localparam logic [8:0] C_IDLE  = 9'b0_0_00_0_0_0_0_0;
  localparam logic [8:0] C_STALL = 9'b1_0_00_0_0_0_0_0;
  localparam logic [8:0] C_SBUSY = 9'b1_0_00_0_0_0_0_1;
  localparam logic [8:0] C_BUSY  = 9'b0_0_00_0_0_0_0_1;
  localparam logic [8:0] C_ACC   = 9'b0_1_01_1_1_0_1_0;
  localparam logic [8:0] C_ERET  = 9'b0_1_10_0_0_1_0_0;

  logic [40:0] exp_q[$];
  string       tag_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic cyc(input string tag, input logic [8:0] ectl, input logic [31:0] eepc);
    logic [40:0] obs, e;
    string       t;
    exp_q.push_back({ectl, eepc});
    tag_q.push_back(tag);
    #4;
    obs = {stall_o, IF_flush_o, PC_sel_o, EPC_we_o, EXL_set_o, EXL_clr_o,
           int_ack_o, mdu_busy_o, EPC_o};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    MemRead_ex_i = 0; rt_ex_i = 0; rs_id_i = 0; rt_id_i = 0;
    use_rs_id_i = 0; use_rt_id_i = 0; valid_id_i = 0; PC_id_i = 0;
    eret_id_i = 0; mdu_start_ex_i = 0; mdu_use_id_i = 0;
    int_req_i = 0; IE_i = 0; EXL_i = 0;
  endtask

  initial begin
    // Reset with inputs that would otherwise stall and accept.
    rst = 1'b1;
    clear_inputs();
    MemRead_ex_i = 1; rt_ex_i = 5'd9; rs_id_i = 5'd9; use_rs_id_i = 1;
    mdu_start_ex_i = 1; mdu_use_id_i = 1;
    int_req_i = 1; IE_i = 1; valid_id_i = 1; PC_id_i = 32'h0000_3010;
    @(negedge clk);
    cyc("reset_outs", C_IDLE, 32'h0);
    rst = 1'b0;
    clear_inputs();
    cyc("idle", C_IDLE, 32'h0);

    // Load-use on rs, one-cycle stall then bubble.
    MemRead_ex_i = 1; rt_ex_i = 5'd9; rs_id_i = 5'd9; use_rs_id_i = 1; valid_id_i = 1;
    cyc("lu_rs", C_STALL, 32'h0);
    MemRead_ex_i = 0;
    cyc("lu_rs_done", C_IDLE, 32'h0);
    // Load-use via rt; then same rt match but not used.
    MemRead_ex_i = 1; use_rs_id_i = 0; rs_id_i = 5'd3; rt_id_i = 5'd9; use_rt_id_i = 1;
    cyc("lu_rt", C_STALL, 32'h0);
    use_rt_id_i = 0;
    cyc("lu_rt_unused", C_IDLE, 32'h0);
    // Load to $zero never stalls.
    rt_ex_i = 5'd0; rs_id_i = 5'd0; use_rs_id_i = 1;
    cyc("lu_r0", C_IDLE, 32'h0);
    clear_inputs();

    // MDU with consumer held: stall cycles 0..5.
    mdu_start_ex_i = 1; mdu_use_id_i = 1;
    cyc("mdu_c0", C_STALL, 32'h0);
    mdu_start_ex_i = 0;
    for (int i = 1; i <= 5; i++) cyc("mdu_busy", C_SBUSY, 32'h0);
    cyc("mdu_done", C_IDLE, 32'h0);
    mdu_use_id_i = 0;

    // Interrupt deferred while the MDU is starting/busy.
    int_req_i = 1; IE_i = 1; valid_id_i = 1; PC_id_i = 32'h0000_3010;
    mdu_start_ex_i = 1;
    cyc("int_mdu_start", C_IDLE, 32'h0);
    mdu_start_ex_i = 0;
    for (int i = 1; i <= 5; i++) cyc("int_mdu_busy", C_BUSY, 32'h0);
    cyc("int_accept", C_ACC, 32'h0000_3010);
    cyc("int_wait_noack", C_IDLE, 32'h0);
    EXL_i = 1;
    cyc("int_wait_exl1", C_IDLE, 32'h0);
    cyc("run_exl1_noack", C_IDLE, 32'h0);
    EXL_i = 0; PC_id_i = 32'h0000_4000;
    cyc("int_reaccept", C_ACC, 32'h0000_4000);
    int_req_i = 0; EXL_i = 1;
    cyc("int_wait_exit", C_IDLE, 32'h0);

    // Interrupt raised during a load-use stall.
    EXL_i = 0; int_req_i = 1; PC_id_i = 32'h0000_5004;
    MemRead_ex_i = 1; rt_ex_i = 5'd7; rs_id_i = 5'd7; use_rs_id_i = 1;
    cyc("int_lu_defer", C_STALL, 32'h0);
    MemRead_ex_i = 0;
    cyc("int_lu_accept", C_ACC, 32'h0000_5004);
    int_req_i = 0; EXL_i = 1;
    cyc("int_lu_exit", C_IDLE, 32'h0);

    // ERET blocked by stall, then taken.
    eret_id_i = 1; MemRead_ex_i = 1;
    cyc("eret_stalled", C_STALL, 32'h0);
    MemRead_ex_i = 0;
    cyc("eret", C_ERET, 32'h0);
    eret_id_i = 0; int_req_i = 1; PC_id_i = 32'h0000_6000;
    cyc("eret_wait_exl1", C_IDLE, 32'h0);
    EXL_i = 0;
    cyc("eret_wait_exl0", C_IDLE, 32'h0);
    cyc("eret_then_int", C_ACC, 32'h0000_6000);
    int_req_i = 0;

    // Now in INT_WAIT; load the MDU and reset at cnt=3.
    mdu_start_ex_i = 1;
    cyc("rst_mdu_start", C_IDLE, 32'h0);
    mdu_start_ex_i = 0;
    cyc("rst_cnt5", C_BUSY, 32'h0);
    cyc("rst_cnt4", C_BUSY, 32'h0);
    rst = 1'b1; mdu_use_id_i = 1; int_req_i = 1;
    cyc("rst_midop", C_IDLE, 32'h0);
    rst = 1'b0; int_req_i = 0;
    cyc("post_rst_cnt0", C_IDLE, 32'h0);
    int_req_i = 1; PC_id_i = 32'h0000_7008;
    cyc("post_rst_run", C_ACC, 32'h0000_7008);
    clear_inputs();
    cyc("final_idle", C_IDLE, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
